// File: rtl/dp_memory_pkg.sv
// Shared types and defaults for the DuckHunt on-chip memories.
package memory_pkg;

  typedef enum logic [0:0] {
    MEM_CLEAR = 1'b0,
    MEM_IDLE  = 1'b1
  } mem_state_t;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_NUM_WORDS = 16;
  localparam int DEF_ADDR_BITS = 4;
  localparam int DEF_LANE_BITS = 8;

  function automatic int num_lanes(input int word_size, input int lane_bits);
    return word_size / lane_bits;
  endfunction

endpackage

// File: rtl/dp_memory_if.sv
// Write/read/clear bundle of the dual-port memory; master drives requests, slave is the memory.
interface dp_memory_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 4,
  parameter int NUM_LANES = 2
);
  logic                 clear;
  logic                 busy;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [NUM_LANES-1:0] wr_be;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 rd_valid;

  modport master (
    output clear, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid
  );
endinterface

// File: rtl/mem_clear_seq.sv
// Clear sequencer: walks every address once after reset or a clear pulse.
module mem_clear_seq
  import memory_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  output logic                 busy,
  output logic                 clr_we,
  output logic [ADDR_BITS-1:0] clr_addr
);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);

  mem_state_t           state_reg, state_next;
  logic [ADDR_BITS-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= MEM_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      MEM_CLEAR: begin
        // A clear pulse mid-sequence starts the sweep over from address 0.
        if (clear) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST_ADDR) begin
          state_next = MEM_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        if (clear) begin
          state_next = MEM_CLEAR;
          cnt_next   = '0;
        end
      end
    endcase
  end

  always_comb begin
    busy     = (state_reg == MEM_CLEAR);
    clr_we   = (state_reg == MEM_CLEAR);
    clr_addr = cnt_reg;
  end

endmodule

// File: rtl/dp_memory.sv
// Simple dual-port RAM with lane enables, write-first forwarding and a clear sequencer.
// Define DP_MEMORY_OUTREG_EN to add a second output register stage (read latency 2).
module dp_memory
  import memory_pkg::*;
#(
  parameter int                   WORD_SIZE  = DEF_WORD_SIZE,
  parameter int                   NUM_WORDS  = DEF_NUM_WORDS,
  parameter int                   ADDR_BITS  = DEF_ADDR_BITS,
  parameter int                   LANE_BITS  = DEF_LANE_BITS,
  parameter logic [WORD_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic       clk,
  input  logic       reset_n,
  dp_memory_if.slave bus
);
  localparam int NUM_LANES = num_lanes(WORD_SIZE, LANE_BITS);

  logic [WORD_SIZE-1:0] mem [NUM_WORDS];

  logic                 busy;
  logic                 clr_we;
  logic [ADDR_BITS-1:0] clr_addr;

  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 user_we;
  logic                 rd_go;
  logic                 fwd_hit;

  logic                 port_we;
  logic [ADDR_BITS-1:0] port_addr;
  logic [NUM_LANES-1:0] port_be;
  logic [WORD_SIZE-1:0] port_data;

  logic [WORD_SIZE-1:0] rd_raw;
  logic [WORD_SIZE-1:0] fwd_word;
  logic [WORD_SIZE-1:0] rd_data_reg;
  logic                 rd_valid_reg;

  mem_clear_seq #(
    .NUM_WORDS (NUM_WORDS),
    .ADDR_BITS (ADDR_BITS)
  ) u_clear_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (bus.clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy    = busy;
  assign wr_in_range = (int'(bus.wr_addr) < NUM_WORDS);
  assign rd_in_range = (int'(bus.rd_addr) < NUM_WORDS);
  assign user_we     = !busy && bus.wr_en && wr_in_range;
  assign rd_go       = !busy && bus.rd_en;
  assign fwd_hit     = user_we && (bus.wr_addr == bus.rd_addr);

  // The sequencer owns the write port for the whole clear sweep.
  always_comb begin
    port_we   = user_we;
    port_addr = bus.wr_addr;
    port_be   = bus.wr_be;
    port_data = bus.wr_data;
    if (clr_we) begin
      port_we   = 1'b1;
      port_addr = clr_addr;
      port_be   = '1;
      port_data = INIT_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (port_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (port_be[i]) begin
          mem[port_addr][i*LANE_BITS +: LANE_BITS] <= port_data[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  always_comb begin
    rd_raw = '0;
    if (rd_in_range) begin
      rd_raw = mem[bus.rd_addr];
    end
  end

  // Write-first: enabled lanes of a same-address write replace the stored lanes.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_fwd
    assign fwd_word[gi*LANE_BITS +: LANE_BITS] =
      (fwd_hit && bus.wr_be[gi]) ? bus.wr_data[gi*LANE_BITS +: LANE_BITS]
                                 : rd_raw[gi*LANE_BITS +: LANE_BITS];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_go;
      if (rd_go) begin
        rd_data_reg <= fwd_word;
      end
    end
  end

`ifdef DP_MEMORY_OUTREG_EN
  logic [WORD_SIZE-1:0] out_data_reg;
  logic                 out_valid_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= rd_valid_reg && !busy;
      if (rd_valid_reg) begin
        out_data_reg <= rd_data_reg;
      end
    end
  end

  // A read in flight when a clear begins must not surface as valid during the sweep.
  assign bus.rd_data  = out_data_reg;
  assign bus.rd_valid = out_valid_reg && !busy;
`else
  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
`endif

endmodule

// File: tb/tb_dp_memory.sv
// Self-checking bench for dp_memory: vector table plus scoreboard on the read port.
module tb_dp_memory;
  import memory_pkg::*;

`ifdef DP_MEMORY_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dp_memory_if #(.WORD_SIZE(16), .ADDR_BITS(4), .NUM_LANES(2)) bus ();
  dp_memory_if #(.WORD_SIZE(16), .ADDR_BITS(4), .NUM_LANES(2)) bus12 ();

  dp_memory #(.WORD_SIZE(16), .NUM_WORDS(16), .ADDR_BITS(4), .LANE_BITS(8), .INIT_VALUE(16'h0000))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  dp_memory #(.WORD_SIZE(16), .NUM_WORDS(12), .ADDR_BITS(4), .LANE_BITS(8), .INIT_VALUE(16'h0000))
    dut12 (.clk(clk), .reset_n(reset_n), .bus(bus12));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected read words queued at issue, popped when rd_valid is due.
  logic [15:0] exp_q[$];
  logic [15:0] last_data = 16'h0000;
  logic        rd_issue  = 1'b0;
  logic [1:0]  pipe      = 2'b00;
  bit          mon_en    = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) pipe = 2'b00;
    else          pipe = {pipe[0], rd_issue};
  end

  always @(negedge reset_n) begin
    pipe = 2'b00;
    exp_q.delete();
    last_data = 16'h0000;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic ev;
      logic [15:0] e;
      ev = pipe[LAT-1];
      check("rd_valid", {31'b0, bus.rd_valid}, {31'b0, ev});
      if (ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=valid required=no_pending_read at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", {16'b0, bus.rd_data}, {16'b0, e});
          $display("read  data=%h expected=%h at %0t", bus.rd_data, e, $time);
          last_data = e;
        end
      end else begin
        check("rd_hold", {16'b0, bus.rd_data}, {16'b0, last_data});
      end
    end
  end

  task automatic drive(input bit we, input logic [3:0] wa, input logic [1:0] be,
                       input logic [15:0] wd, input bit re, input logic [3:0] ra,
                       input logic [15:0] exp);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_be   = be;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    rd_issue    = re;
    if (re) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 16'h0);
  endtask

  // Counts busy-high negedges of both instances over a fixed window.
  task automatic busy_window(input string tag, input int exp16, input int exp12, input int drop_at);
    int n16, n12;
    n16 = 0;
    n12 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n16 += int'(bus.busy);
      n12 += int'(bus12.busy);
      if (i == drop_at) begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_busy16"}, n16, exp16);
    check({tag, "_busy12"}, n12, exp12);
    $display("busy  %s cycles16=%0d cycles12=%0d", tag, n16, n12);
  endtask

  typedef struct {
    bit          we;
    logic [3:0]  wa;
    logic [1:0]  be;
    logic [15:0] wd;
    bit          re;
    logic [3:0]  ra;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  2'b11, 16'hABCD, 1'b0, 4'd0,  16'h0000};
    vecs[1]  = '{1'b1, 4'd3,  2'b01, 16'h1234, 1'b0, 4'd0,  16'h0000};
    vecs[2]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd3,  16'hAB34};
    vecs[3]  = '{1'b1, 4'd5,  2'b11, 16'h1111, 1'b0, 4'd0,  16'h0000};
    vecs[4]  = '{1'b1, 4'd5,  2'b10, 16'h2222, 1'b1, 4'd5,  16'h2211};
    vecs[5]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd5,  16'h2211};
    vecs[6]  = '{1'b1, 4'd9,  2'b00, 16'hFFFF, 1'b1, 4'd9,  16'h0000};
    vecs[7]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd9,  16'h0000};
    vecs[8]  = '{1'b1, 4'd10, 2'b11, 16'hCAFE, 1'b1, 4'd3,  16'hAB34};
    vecs[9]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd10, 16'hCAFE};
    vecs[10] = '{1'b1, 4'd15, 2'b01, 16'h77EE, 1'b1, 4'd0,  16'h0000};
    vecs[11] = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd15, 16'h00EE};

    bus.clear = 1'b0;  bus.wr_en = 1'b0;  bus.wr_addr = '0;  bus.wr_be = '0;
    bus.wr_data = '0;  bus.rd_en = 1'b0;  bus.rd_addr = '0;
    bus12.clear = 1'b0; bus12.wr_en = 1'b0; bus12.wr_addr = '0; bus12.wr_be = '0;
    bus12.wr_data = '0; bus12.rd_en = 1'b0; bus12.rd_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, bus.busy}, 32'd1);
    check("reset_rd_data", {16'b0, bus.rd_data}, 32'd0);
    check("reset_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    mon_en = 1'b1;

    reset_n = 1'b1;
    busy_window("init", 16, 12, 99);

    for (int a = 0; a < 16; a++) drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(a), 16'h0000);
    idle(1);

    for (int i = 0; i < 12; i++) begin
      $display("vec   %0d we=%0b wa=%0d be=%b wd=%h re=%0b ra=%0d exp=%h",
               i, vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].exp);
      drive(vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].exp);
    end
    idle(LAT + 2);

    // Clear pulse while wr_en/rd_en stay asserted: both must be ignored during the sweep.
    bus.clear = 1'b1;
    idle(1);
    bus.clear   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd4;
    bus.wr_be   = 2'b11;
    bus.wr_data = 16'h7777;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd3;
    busy_window("clear", 16, 0, 14);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3,  16'h0000);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd4,  16'h0000);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd10, 16'h0000);
    drive(1'b1, 4'd6, 2'b11, 16'h6666, 1'b0, 4'd0, 16'h0000);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd6,  16'h6666);
    idle(LAT + 2);

    // Reset lands at clear cycle 7: outputs drop at once, sweep restarts after release.
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    idle(7);
    reset_n = 1'b0;
    #1;
    check("midclr_busy", {31'b0, bus.busy}, 32'd1);
    check("midclr_rd_data", {16'b0, bus.rd_data}, 32'd0);
    check("midclr_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    busy_window("rerst", 16, 12, 99);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd6, 16'h0000);
    idle(LAT + 2);

    // Twelve-word instance: out-of-range write is dropped and out-of-range read returns 0.
    bus12.wr_en = 1'b1; bus12.wr_be = 2'b11; bus12.wr_addr = 4'd13; bus12.wr_data = 16'hBEEF;
    @(posedge clk); #1;
    bus12.wr_addr = 4'd2; bus12.wr_data = 16'h0042;
    @(posedge clk); #1;
    bus12.wr_en = 1'b0;
    bus12.rd_en = 1'b1; bus12.rd_addr = 4'd13;
    @(posedge clk); #1;
    bus12.rd_en = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check("w12_oor_valid", {31'b0, bus12.rd_valid}, 32'd1);
    check("w12_oor_data", {16'b0, bus12.rd_data}, 32'd0);
    $display("read12 addr=13 data=%h expected=0000", bus12.rd_data);
    @(posedge clk); #1;
    bus12.rd_en = 1'b1; bus12.rd_addr = 4'd2;
    @(posedge clk); #1;
    bus12.rd_en = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check("w12_a2_valid", {31'b0, bus12.rd_valid}, 32'd1);
    check("w12_a2_data", {16'b0, bus12.rd_data}, 32'h0042);
    $display("read12 addr=2 data=%h expected=0042", bus12.rd_data);
    @(posedge clk); #1;

    idle(LAT + 2);
    check("sb_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_memory.md
Name: dp_memory

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, same clock.
- Adds per-lane write enables, write-first read-during-write forwarding, registered read-valid, and a hardware clear sequencer.
- The sequencer fills the array with INIT_VALUE after reset or on request.
- Serves game-state, sprite and score storage in the DuckHunt hardware. Replaces the single-port, single-address memory.

Parameters:
- WORD_SIZE, 16: bits per word; must be a multiple of LANE_BITS.
- NUM_WORDS, 16: number of stored words, at least 2.
- ADDR_BITS, 4: address width; 2**ADDR_BITS >= NUM_WORDS.
- LANE_BITS, 8: bits per write-enable lane; NUM_LANES = WORD_SIZE/LANE_BITS.
- INIT_VALUE, 0: WORD_SIZE-bit value written by the clear sequencer.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  pulse: re-run the clear sequence
- busy  out  1  high while the clear sequence runs
- wr_en  in  1  write request
- wr_addr  in  ADDR_BITS  write address
- wr_be  in  NUM_LANES  per-lane write enable
- wr_data  in  WORD_SIZE  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_BITS  read address
- rd_data  out  WORD_SIZE  read data
- rd_valid  out  1  rd_data updated this cycle

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - rd_data=0, rd_valid=0, busy=1, state=MEM_CLEAR, clear counter=0.
  - The array is not reset directly; it is initialised by the sequencer.
- State MEM_CLEAR:
  - Each cycle: mem[cnt] <= INIT_VALUE, cnt++.
  - After writing cnt==NUM_WORDS-1, go to MEM_IDLE; busy=0 from the next cycle.
  - busy is high for exactly NUM_WORDS cycles after reset release.
  - wr_en and rd_en are ignored; rd_valid=0; rd_data holds its value.
  - clear asserted during MEM_CLEAR restarts cnt at 0.
- State MEM_IDLE:
  - clear=1 enters MEM_CLEAR next cycle with cnt=0.
  - A write or read presented in the same cycle as clear is still performed.
- Write (MEM_IDLE, wr_en=1): for each lane i with wr_be[i]=1, the lane of mem[wr_addr] takes the matching lane of wr_data. Lanes with wr_be=0 are unchanged; wr_be=0 means no change.
- Read (MEM_IDLE, rd_en=1): rd_data=mem[rd_addr] and rd_valid=1 on the next cycle (latency 1).
- No read: rd_valid=0 and rd_data holds its last value.
- Read-during-write, same address, same cycle: write-first.
  - Returned word takes wr_data lanes where wr_be=1 and old contents elsewhere.
  - Different addresses are independent.
- Out-of-range address (>= NUM_WORDS): the write is dropped; the read returns 0 with rd_valid=1.
- Reset asserted mid-clear or mid-read: outputs go to reset values immediately; the clear sequence restarts from 0 after release.

Optional Feature:
- Macro DP_MEMORY_OUTREG_EN.
- Defined:
  - Extra output register stage; read latency is 2 cycles and rd_valid is delayed to match.
  - Forwarding is still resolved at the first stage.
  - The output stage resets to 0; rd_valid from the stage-two register is 0 while busy.
- Undefined: latency 1 exactly as above.

Decomposition:
- Package memory_pkg holds:
  - state enum mem_state_t {MEM_CLEAR, MEM_IDLE};
  - function num_lanes(word_size, lane_bits);
  - localparam defaults shared with other memories.
- Sub-module mem_clear_seq: counter FSM.
  - Inputs clk, reset_n, clear.
  - Outputs busy, clr_we, clr_addr.
  - dp_memory muxes clr_we/clr_addr/INIT_VALUE onto the write port.

Test Plan (defaults, no macro unless stated):
- Release reset, idle inputs: busy high for exactly 16 cycles. Then reading addresses 0..15 gives 0x0000 each, with rd_valid one cycle after rd_en.
- Write 0xABCD to addr 3, wr_be=11. Then write 0x1234 to addr 3, wr_be=01. Read addr 3: 0xAB34.
- Addr 5 holds 0x1111. Same cycle: write 0x2222 to addr 5 with wr_be=10, and read addr 5. Next cycle rd_data=0x2211; a later read also gives 0x2211.
- Pulse clear after writes: busy high 16 cycles and wr_en/rd_en ignored. Assert reset_n=0 at clear cycle 7: busy stays 1 and rd_data=0. After release busy lasts 16 full cycles.
- NUM_WORDS=12 instance: write 0xBEEF to addr 13 and 0x0042 to addr 2. Read 13 gives 0; read 2 gives 0x0042.
- With DP_MEMORY_OUTREG_EN: write 0x5A5A to addr 7, then read addr 7. rd_valid and 0x5A5A appear 2 cycles after rd_en; back-to-back reads stream one per cycle.
